// File: rtl/div_share_arbiter_if.sv
// ============================================================================
// Module      : div_share_arbiter_if
// Description : Requester and divider channels of the shared-divider arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8
);
    logic [NUM_REQ-1:0]   req_vld;
    logic [NUM_REQ-1:0]   req_rdy;
    logic [NUM_REQ*W-1:0] req_lhs;
    logic [NUM_REQ*W-1:0] req_rhs;
    logic [NUM_REQ-1:0]   resp_vld;
    logic [NUM_REQ-1:0]   resp_rdy;
    logic [W-1:0]         resp_data;
    logic                 resp_dbz;
    logic [W-1:0]         div_lhs;
    logic                 div_lhs_vld;
    logic                 div_lhs_rdy;
    logic [W-1:0]         div_rhs;
    logic                 div_rhs_vld;
    logic                 div_rhs_rdy;
    logic [W-1:0]         div_result;
    logic                 div_result_vld;
    logic                 div_result_rdy;

    // Arbiter side
    modport slave (
        input  req_vld, req_lhs, req_rhs, resp_rdy,
        input  div_lhs_rdy, div_rhs_rdy, div_result, div_result_vld,
        output req_rdy, resp_vld, resp_data, resp_dbz,
        output div_lhs, div_lhs_vld, div_rhs, div_rhs_vld, div_result_rdy
    );

    // Requesters plus divider side
    modport master (
        output req_vld, req_lhs, req_rhs, resp_rdy,
        output div_lhs_rdy, div_rhs_rdy, div_result, div_result_vld,
        input  req_rdy, resp_vld, resp_data, resp_dbz,
        input  div_lhs, div_lhs_vld, div_rhs, div_rhs_vld, div_result_rdy
    );
endinterface

`default_nettype wire

// File: rtl/div_share_arbiter.sv
// ============================================================================
// Module      : div_share_arbiter
// Description : Round-robin sharing of one iterative signed divider; divide-by-
//               zero requests are answered locally with a saturated quotient.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    div_share_arbiter_if.slave bus,
    output logic             busy,
    output logic [15:0]      op_count
);

    localparam int          c_PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [W-1:0] c_MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] c_MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PTR_W-1:0]  r_rr_ptr;
    logic [c_PTR_W-1:0]  r_owner;
    logic [W-1:0]        r_lhs;
    logic [W-1:0]        r_rhs;
    logic [W-1:0]        r_result;
    logic                r_dbz;
    logic                r_lhs_sent;
    logic                r_rhs_sent;
    logic [15:0]         r_op_count;

    logic                w_found;
    logic [c_PTR_W-1:0]  w_grant;
    int                  w_scan_idx;
    logic [W-1:0]        w_sel_lhs;
    logic [W-1:0]        w_sel_rhs;
    logic                w_sel_zero;
    logic [NUM_REQ-1:0]  w_req_rdy;
    logic [NUM_REQ-1:0]  w_resp_vld;
    logic                w_lhs_vld;
    logic                w_rhs_vld;
    logic                w_lhs_fire;
    logic                w_rhs_fire;
    logic                w_res_rdy;
    logic                w_accept;
    logic                w_resp_fire;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && bus.req_vld[w_scan_idx]) begin
                w_found = 1'b1;
                w_grant = c_PTR_W'(w_scan_idx);
            end
        end
    end

    assign w_sel_lhs  = bus.req_lhs[int'(w_grant)*W +: W];
    assign w_sel_rhs  = bus.req_rhs[int'(w_grant)*W +: W];
    assign w_sel_zero = (w_sel_rhs == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_req_rdy   = '0;
        w_resp_vld  = '0;
        w_lhs_vld   = 1'b0;
        w_rhs_vld   = 1'b0;
        w_lhs_fire  = 1'b0;
        w_rhs_fire  = 1'b0;
        w_res_rdy   = 1'b0;
        w_accept    = 1'b0;
        w_resp_fire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_req_rdy[w_grant] = 1'b1;
                    w_accept           = 1'b1;
                    w_state_nxt        = w_sel_zero ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_lhs_vld  = !r_lhs_sent;
                w_rhs_vld  = !r_rhs_sent;
                w_lhs_fire = w_lhs_vld && bus.div_lhs_rdy;
                w_rhs_fire = w_rhs_vld && bus.div_rhs_rdy;
                if ((r_lhs_sent || w_lhs_fire) && (r_rhs_sent || w_rhs_fire))
                    w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_res_rdy = 1'b1;
                if (bus.div_result_vld)
                    w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_resp_vld[r_owner] = 1'b1;
                if (bus.resp_rdy[r_owner]) begin
                    w_resp_fire = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_lhs      <= '0;
            r_rhs      <= '0;
            r_result   <= '0;
            r_dbz      <= 1'b0;
            r_lhs_sent <= 1'b0;
            r_rhs_sent <= 1'b0;
            r_op_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_lhs    <= w_sel_lhs;
                r_rhs    <= w_sel_rhs;
                r_owner  <= w_grant;
                r_rr_ptr <= (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + 1'b1;
                r_dbz    <= w_sel_zero;
                // Saturate toward the sign of the dividend.
                if (w_sel_zero)
                    r_result <= w_sel_lhs[W-1] ? c_MIN_NEG : c_MAX_POS;
            end
            if (r_state == S_ISSUE) begin
                if (w_state_nxt == S_WAIT) begin
                    r_lhs_sent <= 1'b0;
                    r_rhs_sent <= 1'b0;
                end else begin
                    if (w_lhs_fire) r_lhs_sent <= 1'b1;
                    if (w_rhs_fire) r_rhs_sent <= 1'b1;
                end
            end
            if (r_state == S_WAIT && bus.div_result_vld)
                r_result <= bus.div_result;
            if (w_resp_fire)
                r_op_count <= r_op_count + 16'd1;
        end
    end

    assign bus.req_rdy        = w_req_rdy;
    assign bus.resp_vld       = w_resp_vld;
    assign bus.resp_data      = r_result;
    assign bus.resp_dbz       = r_dbz;
    assign bus.div_lhs        = r_lhs;
    assign bus.div_lhs_vld    = w_lhs_vld;
    assign bus.div_rhs        = r_rhs;
    assign bus.div_rhs_vld    = w_rhs_vld;
    assign bus.div_result_rdy = w_res_rdy;
    assign busy               = (r_state != S_IDLE);
    assign op_count           = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
// ============================================================================
// Module      : tb_div_share_arbiter
// Description : Directed self-checking bench for div_share_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_share_arbiter;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] op_count;

    int n_err;
    int n_checks;

    div_share_arbiter_if #(.NUM_REQ(4), .W(8)) bus ();

    div_share_arbiter #(.NUM_REQ(4), .W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: three cycles after both operands arrive, quotient is offered.
    logic signed [7:0] m_l;
    logic signed [7:0] m_r;
    logic              m_hl;
    logic              m_hr;
    int                m_cnt;
    int                n_lhs_xfer;
    int                n_rhs_xfer;
    int                n_div_vld;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_l <= '0; m_r <= '0; m_hl <= 1'b0; m_hr <= 1'b0; m_cnt <= 0;
            bus.div_result <= '0; bus.div_result_vld <= 1'b0;
            n_lhs_xfer <= 0; n_rhs_xfer <= 0; n_div_vld <= 0;
        end else begin
            if (bus.div_lhs_vld || bus.div_rhs_vld) n_div_vld <= n_div_vld + 1;
            if (bus.div_lhs_vld && bus.div_lhs_rdy) begin
                m_l <= bus.div_lhs; m_hl <= 1'b1; n_lhs_xfer <= n_lhs_xfer + 1;
            end
            if (bus.div_rhs_vld && bus.div_rhs_rdy) begin
                m_r <= bus.div_rhs; m_hr <= 1'b1; n_rhs_xfer <= n_rhs_xfer + 1;
            end
            if (m_hl && m_hr && m_cnt == 0 && !bus.div_result_vld) begin
                m_cnt <= 3; m_hl <= 1'b0; m_hr <= 1'b0;
            end
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    bus.div_result     <= m_l / m_r;
                    bus.div_result_vld <= 1'b1;
                end
            end
            if (bus.div_result_vld && bus.div_result_rdy)
                bus.div_result_vld <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] data, output logic dbz, output int lat,
                          output logic [3:0] vld_seen);
        int t;
        @(negedge clk);
        bus.req_vld[idx]          = 1'b1;
        bus.req_lhs[idx*8 +: 8]   = a;
        bus.req_rhs[idx*8 +: 8]   = b;
        #1;
        t = 0;
        while (!bus.req_rdy[idx] && t < 100) begin @(negedge clk); t++; end
        chk("grant_timeout", 32'(t < 100), 32'd1);
        @(negedge clk);
        bus.req_vld[idx] = 1'b0;
        lat = 1;
        while (!bus.resp_vld[idx] && lat < 100) begin @(negedge clk); lat++; end
        chk("resp_timeout", 32'(lat < 100), 32'd1);
        data     = bus.resp_data;
        dbz      = bus.resp_dbz;
        vld_seen = bus.resp_vld;
        bus.resp_rdy[idx] = 1'b1;
        @(negedge clk);
        bus.resp_rdy[idx] = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic       z;
        int         lat;
        logic [3:0] vs;
        int         ngr, nresp, npulse, base_l, base_r, base_v, t;
        logic [1:0] g;
        int         order [8];

        n_err = 0; n_checks = 0;
        rst = 1'b0;
        bus.req_vld = '0; bus.req_lhs = '0; bus.req_rhs = '0; bus.resp_rdy = '0;
        bus.div_lhs_rdy = 1'b1; bus.div_rhs_rdy = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_resp_vld", 32'(bus.resp_vld), 32'd0);
        chk("rst_div_vld", 32'({bus.div_lhs_vld, bus.div_rhs_vld, bus.div_result_rdy}), 32'd0);
        chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
        rst = 1'b1;

        // Single request from requester 1
        run_op(1, 8'd100, 8'd7, d, z, lat, vs);
        chk("single_data", 32'(d), 32'h0E);
        chk("single_dbz", 32'(z), 32'd0);
        chk("single_vld_onehot", 32'(vs), 32'b0010);
        chk("single_div_lhs", 32'(m_l), 32'd100);
        chk("single_div_rhs", 32'(m_r), 32'd7);
        chk("single_op_count", 32'(op_count), 32'd1);

        // Divide by zero from requester 2
        base_v = n_div_vld;
        run_op(2, 8'd5, 8'd0, d, z, lat, vs);
        chk("dbz_pos_data", 32'(d), 32'h7F);
        chk("dbz_pos_flag", 32'(z), 32'd1);
        chk("dbz_pos_latency", 32'(lat), 32'd1);
        chk("dbz_pos_onehot", 32'(vs), 32'b0100);
        run_op(2, 8'hFB, 8'd0, d, z, lat, vs);
        chk("dbz_neg_data", 32'(d), 32'h80);
        chk("dbz_neg_flag", 32'(z), 32'd1);
        chk("dbz_no_div_vld", 32'(n_div_vld - base_v), 32'd0);

        // Signed operand pairs; last grant on requester 3 leaves the pointer at 0
        run_op(0, 8'h9C, 8'd7, d, z, lat, vs);
        chk("neg_pos", 32'(d), 32'hF2);
        run_op(1, 8'd100, 8'hF9, d, z, lat, vs);
        chk("pos_neg", 32'(d), 32'hF2);
        run_op(3, 8'h9C, 8'hF9, d, z, lat, vs);
        chk("neg_neg", 32'(d), 32'h0E);
        chk("neg_neg_dbz", 32'(z), 32'd0);
        chk("signed_op_count", 32'(op_count), 32'd6);

        // All four requesting continuously, responses accepted at once
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.req_lhs[i*8 +: 8] = 8'((i + 1) * 10);
            bus.req_rhs[i*8 +: 8] = 8'd2;
        end
        bus.req_vld  = 4'hF;
        bus.resp_rdy = 4'hF;
        ngr = 0; nresp = 0; npulse = 0;
        for (int c = 0; c < 400 && nresp < 8; c++) begin
            #1;
            if (bus.req_rdy != '0) begin
                npulse++;
                g = 2'd0;
                for (int i = 0; i < 4; i++) if (bus.req_rdy[i]) g = 2'(i);
                if (ngr < 8) order[ngr] = int'(g);
                ngr++;
            end
            if (bus.resp_vld != '0) begin
                g = 2'd0;
                for (int i = 0; i < 4; i++) if (bus.resp_vld[i]) g = 2'(i);
                chk("rr_resp_data", 32'(bus.resp_data), 32'((int'(g) + 1) * 5));
                nresp++;
                if (nresp == 8) bus.req_vld = '0;
            end
            @(negedge clk);
        end
        bus.resp_rdy = '0;
        chk("rr_responses", 32'(nresp), 32'd8);
        chk("rr_rdy_pulses", 32'(npulse), 32'd8);
        for (int k = 0; k < 8; k++)
            chk("rr_order", 32'(order[k]), 32'(k % 4));
        chk("rr_op_count", 32'(op_count), 32'd14);

        // Divider lhs back-pressure for three cycles
        bus.div_lhs_rdy = 1'b0;
        base_l = n_lhs_xfer; base_r = n_rhs_xfer;
        bus.req_vld[0] = 1'b1; bus.req_lhs[7:0] = 8'd100; bus.req_rhs[7:0] = 8'd7;
        #1;
        t = 0;
        while (!bus.req_rdy[0] && t < 100) begin @(negedge clk); t++; end
        chk("bp_grant_timeout", 32'(t < 100), 32'd1);
        @(negedge clk);
        bus.req_vld[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_lhs_vld", 32'(bus.div_lhs_vld), 32'd1);
            chk("bp_lhs_data", 32'(bus.div_lhs), 32'd100);
            if (c > 0) chk("bp_rhs_vld_low", 32'(bus.div_rhs_vld), 32'd0);
            if (c < 2) @(negedge clk);
        end
        chk("bp_rhs_once", 32'(n_rhs_xfer - base_r), 32'd1);
        chk("bp_lhs_none", 32'(n_lhs_xfer - base_l), 32'd0);
        bus.div_lhs_rdy = 1'b1;
        @(negedge clk);
        chk("bp_wait_rdy", 32'(bus.div_result_rdy), 32'd1);
        chk("bp_lhs_vld_off", 32'(bus.div_lhs_vld), 32'd0);
        chk("bp_lhs_once", 32'(n_lhs_xfer - base_l), 32'd1);
        t = 0;
        while (!bus.resp_vld[0] && t < 100) begin @(negedge clk); t++; end
        chk("bp_data", 32'(bus.resp_data), 32'h0E);
        bus.resp_rdy[0] = 1'b1;
        @(negedge clk);
        bus.resp_rdy[0] = 1'b0;
        chk("bp_rhs_once_end", 32'(n_rhs_xfer - base_r), 32'd1);

        // Response stalled five cycles
        bus.req_vld[0] = 1'b1; bus.req_lhs[7:0] = 8'd77; bus.req_rhs[7:0] = 8'd7;
        #1;
        t = 0;
        while (!bus.req_rdy[0] && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        bus.req_vld[0] = 1'b0;
        t = 0;
        while (!bus.resp_vld[0] && t < 100) begin @(negedge clk); t++; end
        for (int c = 0; c < 5; c++) begin
            chk("stall_vld", 32'(bus.resp_vld), 32'b0001);
            chk("stall_data", 32'({bus.resp_dbz, bus.resp_data}), 32'h00B);
            @(negedge clk);
        end
        bus.resp_rdy[0] = 1'b1;
        @(negedge clk);
        bus.resp_rdy[0] = 1'b0;
        chk("stall_op_count", 32'(op_count), 32'd16);

        // Asynchronous reset during WAIT
        bus.req_vld[1] = 1'b1; bus.req_lhs[15:8] = 8'd50; bus.req_rhs[15:8] = 8'd5;
        #1;
        t = 0;
        while (!bus.req_rdy[1] && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        bus.req_vld[1] = 1'b0;
        t = 0;
        while (!bus.div_result_rdy && t < 100) begin @(negedge clk); t++; end
        chk("arst_reached_wait", 32'(bus.div_result_rdy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_op_count", 32'(op_count), 32'd0);
        chk("arst_res_rdy", 32'(bus.div_result_rdy), 32'd0);
        chk("arst_outputs", 32'({bus.resp_vld, bus.req_rdy, bus.resp_data}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Operation after reset
        run_op(3, 8'd1, 8'd0, d, z, lat, vs);
        chk("post_rst_data", 32'({z, d}), 32'h17F);
        chk("post_rst_op_count", 32'(op_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
- Shares one iterative signed divider between NUM_REQ requesters.
- Each requester offers an operand pair on a valid/ready channel. The block grants one requester round-robin, issues the operands on the divider's separate lhs/rhs channels, waits for the divider result, and returns the result to the granted requester only.
- Divide-by-zero requests never reach the divider, because the divider never terminates on rhs = 0; the block answers them locally.
- The block sits between the requesters and the divider, one level above the divider in the datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- W, 8, operand and result width in bits; must equal the divider width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_vld  input  NUM_REQ  per-requester request valid.
- req_rdy  output  NUM_REQ  per-requester request accept; one-hot or zero.
- req_lhs  input  NUM_REQ*W  dividends; requester i in bits [i*W +: W], signed.
- req_rhs  input  NUM_REQ*W  divisors, same packing, signed.
- resp_vld  output  NUM_REQ  per-requester result valid; one-hot or zero.
- resp_rdy  input  NUM_REQ  per-requester result accept.
- resp_data  output  W  quotient, shared by all requesters; qualified by resp_vld.
- resp_dbz  output  1  divide-by-zero flag, qualified by resp_vld.
- div_lhs / div_lhs_vld  output  W / 1  dividend channel to the divider.
- div_lhs_rdy  input  1  dividend channel accept from the divider.
- div_rhs / div_rhs_vld  output  W / 1  divisor channel to the divider.
- div_rhs_rdy  input  1  divisor channel accept from the divider.
- div_result  input  W  quotient from the divider.
- div_result_vld  input  1  quotient valid from the divider.
- div_result_rdy  output  1  quotient accept to the divider.
- busy  output  1  high in any state other than IDLE.
- op_count  output  16  completed responses; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst low, async): state = IDLE, rr_ptr = 0, op_count = 0. All vld/rdy outputs and busy are 0. Data outputs are 0. A reset mid-operation abandons the operation. System-level reset must reset the divider in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_vld[i], searching from rr_ptr upward and wrapping.
  - In that same cycle req_rdy[g] = 1 (combinational).
  - At the clock edge: capture lhs/rhs of g into operand registers, owner = g, rr_ptr = (g+1) mod NUM_REQ.
  - If rhs == 0: go to RESP with result = (lhs sign 0 ? max positive : min negative) and dbz = 1.
  - Otherwise go to ISSUE with dbz = 0.
  - With no req_vld, stay in IDLE.
- ISSUE:
  - div_lhs_vld = !lhs_sent and div_rhs_vld = !rhs_sent; data is taken from the operand registers.
  - A channel transfers on vld & rdy in the same cycle, then sets its sent flag. The two channels may complete in different cycles.
  - Once both have transferred (flags set, or set this cycle), go to WAIT and clear both flags.
  - vld must never drop before its transfer.
- WAIT: div_result_rdy = 1. On div_result_vld, latch div_result and go to RESP.
  - div_result_vld seen in any other state is a protocol error; it is ignored and div_result_rdy stays 0.
- RESP:
  - resp_vld[owner] = 1, resp_data = latched result, resp_dbz = latched flag; these hold stable until resp_rdy[owner].
  - On handshake: op_count += 1, go to IDLE.
  - A new grant occurs no earlier than the next cycle, giving one IDLE cycle between operations.
- Only one operation is outstanding at a time. req_rdy is 0 outside IDLE.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 other grants.
- Minimum latency for a dbz request, request to resp_vld: 1 cycle (IDLE -> RESP). A normal request adds the divider latency on top of ISSUE and WAIT.
- Arithmetic: operands pass unmodified. The -min/-1 case is not intercepted; its result is whatever the divider returns.

Test Plan:
- Single request, requester 1: lhs=100, rhs=7 -> divider sees 100/7. resp_vld[1] returns 14 with dbz=0, op_count=1, other resp_vld stay 0.
- Signed operand pairs: lhs=-100, rhs=7 -> -14 (0xF2). lhs=100, rhs=-7 -> -14. lhs=-100, rhs=-7 -> 14.
- All 4 requesters held valid continuously, responses accepted immediately -> grant order 0,1,2,3,0,… Each req_rdy pulses exactly once per grant.
- Divide by zero from requester 2: lhs=5, rhs=0 -> resp_vld[2] the cycle after the grant with data 0x7F, dbz=1. lhs=-5, rhs=0 -> 0x80. div_*_vld never rises.
- Divider back-pressure: div_lhs_rdy held low 3 cycles while div_rhs_rdy is high -> rhs transfers once, lhs_vld stays high with stable data, then lhs transfers once and the FSM moves to WAIT.
- resp_rdy[0] held low 5 cycles, then async reset asserted during a later WAIT -> resp data stays stable while stalled. On reset, outputs clear immediately and the FSM is in IDLE with op_count=0.
